// File: rtl/rom_reader.sv
// rom_reader: walks base..base+count-1 on a 1-cycle-latency ROM and emits the words as a valid/ready stream.
// Define ROM_READER_LOOP_EN to add the 'loop' input that restarts the burst seamlessly instead of ending it.
`timescale 1ns/1ps
module rom_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4096,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base,
  input  logic [AW:0]      count,
  output logic             busy,
  output logic             done,
  output logic             rom_en,
  output logic [AW-1:0]    rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef ROM_READER_LOOP_EN
  input  logic             loop,
`endif
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             dbg_state
);

  // Stream contract: a beat transfers on a cycle with out_valid && out_ready; while
  // out_valid is high and out_ready low, no read is issued so the ROM holds out_data.
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_rem;
  logic          r_valid;
  logic          r_last;
  logic          r_busy;
  logic          r_done;

  logic          w_accept;
  logic          w_end;
  logic          w_reload;
  logic          w_issue;
  logic [AW-1:0] w_issue_addr;
  logic [AW-1:0] w_next_addr;
  logic [AW:0]   w_issue_rem;

  assign w_accept = r_valid && out_ready;
  assign w_end    = (r_state == S_RUN) && w_accept && r_last;

`ifdef ROM_READER_LOOP_EN
  logic [AW-1:0] r_base;
  logic [AW:0]   r_count;

  // On a looping end-of-burst the next read uses the reloaded range in the same cycle.
  assign w_reload     = w_end && loop;
  assign w_issue_addr = w_reload ? r_base  : r_addr;
  assign w_issue_rem  = w_reload ? r_count : r_rem;
`else
  assign w_reload     = 1'b0;
  assign w_issue_addr = r_addr;
  assign w_issue_rem  = r_rem;
`endif

  assign w_issue     = (r_state == S_RUN) && (w_issue_rem != '0) && (!r_valid || out_ready);
  assign w_next_addr = (w_issue_addr == AW'(DEPTH - 1)) ? '0 : w_issue_addr + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef ROM_READER_LOOP_EN
      r_base  <= '0;
      r_count <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (count != '0) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_addr  <= base;
              r_rem   <= count;
`ifdef ROM_READER_LOOP_EN
              r_base  <= base;
              r_count <= count;
`endif
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_addr  <= w_next_addr;
            r_rem   <= w_issue_rem - 1'b1;
            r_valid <= 1'b1;
            r_last  <= (w_issue_rem == (AW+1)'(1));
          end else if (w_accept) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end
          if (w_end && !w_reload) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rom_en    = w_issue;
  assign rom_addr  = w_issue_addr;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign out_data  = rom_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = (r_state == S_RUN);

endmodule

// File: tb/tb_rom_reader.sv
// tb_rom_reader: table-driven and randomized bursts against a ROM model and a queue-based stream model.
`timescale 1ns/1ps
module tb_rom_reader;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4096;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AW-1:0]    base;
  logic [AW:0]      count;
  logic             busy, done, rom_en;
  logic [AW-1:0]    rom_addr;
  logic [WIDTH-1:0] rom_data = '0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, out_ready, out_last, dbg_state;
`ifdef ROM_READER_LOOP_EN
  logic             loop = 1'b0;
`endif

  always #5 clk = ~clk;

  rom_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
    .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef ROM_READER_LOOP_EN
    .loop(loop),
`endif
    .out_data(out_data), .out_last(out_last), .dbg_state(dbg_state)
  );

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   count;
    int            mode;     // 0: ready high, 1: ready 1,0,0 pattern, 2: random ready
    int            exp_lat;  // start-to-done cycles, -1 when ready is not held high
    int            restart;  // cycle offset of an extra start while busy, 0 = none
  } vec_t;

  int               n_checks = 0;
  int               n_fail   = 0;
  int               n_beats  = 0;
  int               n_done   = 0;
  logic [WIDTH:0]   exp_q[$];
  logic [AW-1:0]    addr_q[$];
  logic             held_valid = 1'b0;
  logic [WIDTH-1:0] held_data  = '0;

  function automatic logic [WIDTH-1:0] rom_word(input int a);
    logic [7:0] hi;
    hi = 8'(a >>> 8);
    return 8'(a) ^ 8'(hi * 8'h35);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a burst is count words from base upward modulo DEPTH, last flag on the final one.
  task automatic model_push(input logic [AW-1:0] b, input logic [AW:0] c);
    int a;
    for (int k = 0; k < int'(c); k++) begin
      a = (int'(b) + k) % DEPTH;
      addr_q.push_back(AW'(a));
      exp_q.push_back({(k == int'(c) - 1), rom_word(a)});
    end
  endtask

  function automatic logic ready_at(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // Synchronous ROM: registered read when enabled, output held otherwise.
  always @(posedge clk) if (rom_en) rom_data <= rom_word(int'(rom_addr));

  always @(negedge clk) begin : mon
    logic [WIDTH:0] e;
    logic [AW-1:0]  a;
    if (rst) begin
      held_valid = 1'b0;
    end else begin
      if (rom_en) begin
        if (addr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_issue: got read of %0h, required no read", rom_addr);
        end else begin
          a = addr_q.pop_front();
          check("rom_addr", 32'(rom_addr), 32'(a));
        end
      end
      if (held_valid) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_hold", 32'(out_data), 32'(held_data));
      end
      if (out_valid && !out_ready) check("en_in_stall", 32'(rom_en), 32'd0);
      if (out_valid && out_ready) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_beat: got beat %0h, required none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(out_data), 32'(e[WIDTH-1:0]));
          check("beat_last", 32'(out_last), 32'(e[WIDTH]));
        end
      end
      held_valid = out_valid && !out_ready;
      held_data  = out_data;
      if (done) n_done++;
    end
  end

  task automatic run_burst(input vec_t v);
    int lat, d0, budget;
    lat    = -1;
    d0     = n_done;
    budget = 4 * int'(v.count) + 40;
    model_push(v.base, v.count);
    @(posedge clk); #1;
    base = v.base; count = v.count; start = 1'b1; out_ready = ready_at(v.mode, 0);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(posedge clk); #1;
      start     = (cyc == v.restart);
      base      = AW'($urandom);
      count     = (AW+1)'($urandom_range(1, 20));
      out_ready = ready_at(v.mode, cyc);
      @(negedge clk);
      if (cyc == 1) check("busy_after_start", 32'(busy), 32'(v.count != 0));
      if (done) begin
        lat = cyc;
        check("busy_at_done", 32'(busy), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b1;
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles, required done", budget);
    end else if (v.exp_lat >= 0) begin
      check("done_latency", 32'(lat), 32'(v.exp_lat));
    end
    @(negedge clk);
    check("done_width", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("done_pulses", 32'(n_done - d0), 32'd1);
    check("beats_drained", 32'(exp_q.size()), 32'd0);
    check("reads_drained", 32'(addr_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required end before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vec_t rv;
    vecs[0] = '{12'h010, 13'd4,    0, 6,    0};
    vecs[1] = '{12'h010, 13'd4,    1, -1,   0};
    vecs[2] = '{12'hFFE, 13'd4,    0, 6,    0};
    vecs[3] = '{12'h000, 13'd0,    0, 1,    0};
    vecs[4] = '{12'h040, 13'd5,    0, 7,    2};
    vecs[5] = '{12'hFFF, 13'd1,    1, -1,   0};
    vecs[6] = '{12'h123, 13'd1,    0, 3,    0};
    vecs[7] = '{12'h800, 13'd4098, 0, 4100, 0};
    vecs[8] = '{12'h7F0, 13'd20,   2, -1,   0};

    rst = 1'b1; start = 1'b0; base = '0; count = '0; out_ready = 1'b1;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rom_en", 32'(rom_en), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < 9; i++) run_burst(vecs[i]);

    for (int i = 0; i < 12; i++) begin
      rv.base    = AW'($urandom);
      rv.count   = (AW+1)'($urandom_range(1, 24));
      rv.mode    = (i % 2 == 0) ? 0 : 2;
      rv.exp_lat = (rv.mode == 0) ? int'(rv.count) + 2 : -1;
      rv.restart = (i % 3 == 1) ? 3 : 0;
      run_burst(rv);
    end

    // Asynchronous reset between clock edges in the middle of a burst.
    model_push(12'h200, 13'd10);
    @(posedge clk); #1; base = 12'h200; count = 13'd10; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #3; rst = 1'b1; #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_rom_en", 32'(rom_en), 32'd0);
    check("arst_rom_addr", 32'(rom_addr), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_last", 32'(out_last), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    exp_q.delete(); addr_q.delete();
    @(posedge clk); #1; rst = 1'b0;
    rv = '{12'h3A0, 13'd6, 0, 8, 0};
    run_burst(rv);

`ifdef ROM_READER_LOOP_EN
    begin
      int lat, d0, b0;
      lat = -1; d0 = n_done; b0 = n_beats;
      for (int p = 0; p < 3; p++) model_push(12'h000, 13'd3);
      @(posedge clk); #1;
      loop = 1'b1; base = 12'h000; count = 13'd3; start = 1'b1; out_ready = 1'b1;
      for (int cyc = 1; cyc <= 60; cyc++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (n_beats - b0 >= 6) loop = 1'b0;
        @(negedge clk);
        if (done) begin lat = cyc; break; end
      end
      @(posedge clk); #1; loop = 1'b0;
      if (lat < 0) begin
        n_checks++; n_fail++;
        $display("FAIL loop_timeout: got no done, required done after third pass");
      end else begin
        check("loop_latency", 32'(lat), 32'd11);
      end
      @(posedge clk); #1;
      check("loop_done_pulses", 32'(n_done - d0), 32'd1);
      check("loop_beats", 32'(n_beats - b0), 32'd9);
      check("loop_drained", 32'(exp_q.size()), 32'd0);
    end
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
